// File: rtl/fifo_pkg.sv
// Shared definitions for the byte-FIFO drain path: byte width and the
// packer's two-state controller encoding.
package fifo_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_t;

endpackage

// File: rtl/fifo_word_packer_if.sv
// Packed-word output stream of fifo_word_packer: valid/ready handshake with
// the packed little-endian word and its count of valid bytes.
interface fifo_word_packer_if
    import fifo_pkg::*;
#(
    parameter int WORD_BYTES = 4
) ();

    logic                             out_word_valid;
    logic                             in_word_ready;
    logic [BYTE_W*WORD_BYTES-1:0]     out_word_data;
    logic [$clog2(WORD_BYTES):0]      out_word_byte_cnt;

    // Packer side: produces the word, consumes ready.
    modport master (
        output out_word_valid,
        output out_word_data,
        output out_word_byte_cnt,
        input  in_word_ready
    );

    // Downstream side: consumes the word, produces ready.
    modport slave (
        input  out_word_valid,
        input  out_word_data,
        input  out_word_byte_cnt,
        output in_word_ready
    );

endinterface

// File: rtl/fifo_word_packer.sv
// Drain stage for the 8-bit byte FIFO. Pops bytes (the FIFO returns data one
// cycle after a sampled pop), packs them little-endian into WORD_BYTES-wide
// words and presents each word on a valid/ready stream. A flush pulse emits
// the current partial word once any in-flight byte has landed.
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int WORD_BYTES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_fifo_is_empty,
    input  logic [BYTE_W-1:0]  in_fifo_read_data,
    output logic               out_fifo_read_ctrl,
    input  logic               in_flush,
    fifo_word_packer_if.master word_if
);

    localparam int                 CNT_W    = $clog2(WORD_BYTES) + 1;
    localparam int                 DATA_W   = BYTE_W * WORD_BYTES;
    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(WORD_BYTES);
    localparam logic [CNT_W:0]     FULL_EXT = (CNT_W + 1)'(WORD_BYTES);

    pack_state_t        r_state;
    pack_state_t        w_state_nxt;
    logic [CNT_W-1:0]   r_byte_cnt;
    logic [CNT_W-1:0]   w_byte_cnt_nxt;
    logic [DATA_W-1:0]  r_data;
    logic [DATA_W-1:0]  w_data_nxt;
    logic               r_rd_pend;
    logic               r_flush_pend;
    logic               w_flush_pend_nxt;
    logic               r_valid;
    logic               w_rd_ctrl;
    logic               w_accept;
    logic [CNT_W:0]     w_inflight;

    // Bytes already owned by the current word, counting one still in flight.
    assign w_inflight = {1'b0, r_byte_cnt} + {{CNT_W{1'b0}}, r_rd_pend};
    assign w_accept   = r_valid && word_if.in_word_ready;

    // Next-state, byte capture/lane decode, flush bookkeeping and pop request.
    always_comb begin
        w_state_nxt      = r_state;
        w_byte_cnt_nxt   = r_byte_cnt;
        w_data_nxt       = r_data;
        w_flush_pend_nxt = r_flush_pend || in_flush;
        w_rd_ctrl        = 1'b0;
        case (r_state)
            FILL: begin
                w_rd_ctrl = rst && !in_fifo_is_empty && !r_flush_pend
                            && (w_inflight < FULL_EXT);
                if (r_rd_pend) begin
                    // Landed byte goes to lane byte_cnt; a pending flush waits for it.
                    for (int i = 0; i < WORD_BYTES; i++) begin
                        if (r_byte_cnt == CNT_W'(i)) begin
                            w_data_nxt[i*BYTE_W +: BYTE_W] = in_fifo_read_data;
                        end else begin
                            w_data_nxt[i*BYTE_W +: BYTE_W] = r_data[i*BYTE_W +: BYTE_W];
                        end
                    end
                    w_byte_cnt_nxt = r_byte_cnt + CNT_W'(1);
                    if (w_byte_cnt_nxt == FULL_CNT) begin
                        w_state_nxt = HOLD;
                    end else begin
                        w_state_nxt = FILL;
                    end
                end else if (r_flush_pend) begin
                    if (r_byte_cnt != {CNT_W{1'b0}}) begin
                        // Partial word goes out; flush_pend is absorbed at the handshake.
                        w_state_nxt = HOLD;
                    end else begin
                        // Nothing buffered: the flush completes silently.
                        w_flush_pend_nxt = in_flush;
                    end
                end else begin
                    w_state_nxt = FILL;
                end
            end
            HOLD: begin
                if (w_accept) begin
                    w_state_nxt      = FILL;
                    w_byte_cnt_nxt   = {CNT_W{1'b0}};
                    w_data_nxt       = {DATA_W{1'b0}};
                    w_flush_pend_nxt = 1'b0;
                end else begin
                    w_state_nxt = HOLD;
                end
            end
            default: begin
                w_state_nxt = FILL;
            end
        endcase
    end

    // State, word buffer and handshake registers; reset drops any partial word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= FILL;
            r_byte_cnt   <= {CNT_W{1'b0}};
            r_data       <= {DATA_W{1'b0}};
            r_rd_pend    <= 1'b0;
            r_flush_pend <= 1'b0;
            r_valid      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_data       <= w_data_nxt;
            r_rd_pend    <= w_rd_ctrl;
            r_flush_pend <= w_flush_pend_nxt;
            r_valid      <= (w_state_nxt == HOLD);
        end
    end

    assign out_fifo_read_ctrl        = w_rd_ctrl;
    assign word_if.out_word_valid    = r_valid;
    assign word_if.out_word_data     = r_data;
    assign word_if.out_word_byte_cnt = r_byte_cnt;

    a_no_read_when_empty : assert property (@(posedge clk) disable iff (!rst)
        out_fifo_read_ctrl |-> !in_fifo_is_empty);

    a_word_stable : assert property (@(posedge clk) disable iff (!rst)
        (r_valid && !word_if.in_word_ready) |=> ($stable(r_data) && $stable(r_byte_cnt)));

    a_cnt_bound : assert property (@(posedge clk) disable iff (!rst)
        r_byte_cnt <= FULL_CNT);

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: a small behavioural byte FIFO feeds the packer;
// table vectors cover whole and flushed words, hand sequences cover
// backpressure, flush races, empty flush and mid-word reset.
module tb_fifo_word_packer;
    import fifo_pkg::*;

    localparam int WB = 4;
    localparam int CW = $clog2(WB) + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_rdata;
    logic       rd_ctrl;
    logic       flush = 1'b0;
    logic       push = 1'b0;
    logic [7:0] push_data = 8'h00;

    fifo_word_packer_if #(.WORD_BYTES(WB)) word_if ();

    fifo_word_packer #(.WORD_BYTES(WB)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_fifo_is_empty  (fifo_empty),
        .in_fifo_read_data (fifo_rdata),
        .out_fifo_read_ctrl(rd_ctrl),
        .in_flush          (flush),
        .word_if           (word_if.master)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: registered empty, read data one cycle after the pop.
    logic [7:0] mem [64];
    int wptr = 0, rptr = 0, count = 0;
    int rd_cnt = 0, hs_cnt = 0, bad_rd = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= 0; rptr <= 0; count <= 0; fifo_rdata <= 8'h00;
        end else begin
            if (rd_ctrl) begin
                fifo_rdata <= mem[rptr % 64];
                rptr <= rptr + 1;
            end
            if (push) begin
                mem[wptr % 64] <= push_data;
                wptr <= wptr + 1;
            end
            count <= count + (push ? 1 : 0) - (rd_ctrl ? 1 : 0);
        end
    end
    assign fifo_empty = (count == 0);

    always @(posedge clk) begin
        if (rst && rd_ctrl) rd_cnt <= rd_cnt + 1;
        if (rst && rd_ctrl && fifo_empty) bad_rd <= bad_rd + 1;
        if (rst && word_if.out_word_valid && word_if.in_word_ready) hs_cnt <= hs_cnt + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic push_bytes(input int n, input logic [63:0] b);
        for (int i = 0; i < n; i++) begin
            push = 1'b1;
            push_data = b[8*i +: 8];
            @(negedge clk);
        end
        push = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (word_if.out_word_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({name, " valid_seen"}, 64'(ok), 64'd1);
    endtask

    typedef struct {
        string           name;
        int              n;
        logic [63:0]     bytes;
        bit              do_flush;
        logic [31:0]     exp_data;
        logic [CW-1:0]   exp_cnt;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base, hbase;
        bit found, seen;

        vecs[0] = '{"full_11223344", 4, 64'h44332211, 1'b0, 32'h44332211, 3'd4};
        vecs[1] = '{"flush_aabbcc",  3, 64'h00CCBBAA, 1'b1, 32'h00CCBBAA, 3'd3};
        vecs[2] = '{"flush_one",     1, 64'h0000005A, 1'b1, 32'h0000005A, 3'd1};
        vecs[3] = '{"full_deadbeef", 4, 64'hEFBEADDE, 1'b0, 32'hEFBEADDE, 3'd4};
        vecs[4] = '{"flush_two",     2, 64'h00009C7E, 1'b1, 32'h00009C7E, 3'd2};

        word_if.in_word_ready = 1'b0;

        // Reset held with random activity on the inputs.
        for (int i = 0; i < 3; i++) begin
            flush = 1'($urandom_range(0, 1));
            word_if.in_word_ready = 1'($urandom_range(0, 1));
            push = 1'($urandom_range(0, 1));
            push_data = 8'($urandom_range(0, 255));
            @(negedge clk);
            check("rst_valid", 64'(word_if.out_word_valid), 64'd0);
            check("rst_data",  64'(word_if.out_word_data), 64'd0);
            check("rst_cnt",   64'(word_if.out_word_byte_cnt), 64'd0);
            check("rst_rdctl", 64'(rd_ctrl), 64'd0);
        end
        flush = 1'b0; push = 1'b0; word_if.in_word_ready = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_empty_rdctl", 64'(rd_ctrl), 64'd0);
        end

        // Table-driven whole and flushed words with ready held high.
        word_if.in_word_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            base = rd_cnt; hbase = hs_cnt;
            push_bytes(vecs[v].n, vecs[v].bytes);
            if (vecs[v].do_flush) begin
                idle(4);
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
            end
            wait_valid(vecs[v].name);
            check({vecs[v].name, " data"}, 64'(word_if.out_word_data), 64'(vecs[v].exp_data));
            check({vecs[v].name, " cnt"}, 64'(word_if.out_word_byte_cnt), 64'(vecs[v].exp_cnt));
            @(negedge clk);
            check({vecs[v].name, " valid_one_cycle"}, 64'(word_if.out_word_valid), 64'd0);
            idle(3);
            check({vecs[v].name, " reads"}, 64'(rd_cnt - base), 64'(vecs[v].n));
            check({vecs[v].name, " words"}, 64'(hs_cnt - hbase), 64'd1);
        end

        // Backpressure: 8 bytes pushed, only the first word is taken.
        word_if.in_word_ready = 1'b0;
        base = rd_cnt;
        push_bytes(8, 64'h0807060504030201);
        wait_valid("bp_first");
        check("bp_first data", 64'(word_if.out_word_data), 64'h04030201);
        check("bp_first cnt", 64'(word_if.out_word_byte_cnt), 64'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold data", 64'(word_if.out_word_data), 64'h04030201);
        end
        check("bp_hold valid", 64'(word_if.out_word_valid), 64'd1);
        check("bp_reads", 64'(rd_cnt - base), 64'd4);
        check("bp_fifo_level", 64'(count), 64'd4);
        word_if.in_word_ready = 1'b1;
        @(negedge clk);
        wait_valid("bp_second");
        check("bp_second data", 64'(word_if.out_word_data), 64'h08070605);
        idle(3);
        check("bp_reads_total", 64'(rd_cnt - base), 64'd8);

        // Flush with nothing buffered: pend sets then clears, no word.
        hbase = hs_cnt;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("eflush pend_set", 64'(dut.r_flush_pend), 64'd1);
        @(negedge clk);
        check("eflush pend_clr", 64'(dut.r_flush_pend), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (word_if.out_word_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("eflush no_word", 64'(seen), 64'd0);
        check("eflush words", 64'(hs_cnt - hbase), 64'd0);

        // Flush in the same cycle as the third byte's pop request.
        base = rd_cnt; hbase = hs_cnt;
        push_bytes(3, 64'h00333231);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (rd_ctrl && (rd_cnt - base == 2)) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("race found_third_read", 64'(found), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_valid("race");
        check("race cnt", 64'(word_if.out_word_byte_cnt), 64'd3);
        check("race data", 64'(word_if.out_word_data), 64'h00333231);
        idle(3);
        check("race words", 64'(hs_cnt - hbase), 64'd1);

        // Flush coinciding with the final byte capture: one full word only.
        base = rd_cnt; hbase = hs_cnt;
        push_bytes(4, 64'h44434241);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if ((rd_cnt - base == 4) && !word_if.out_word_valid) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("lastflush found_capture", 64'(found), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_valid("lastflush");
        check("lastflush data", 64'(word_if.out_word_data), 64'h44434241);
        check("lastflush cnt", 64'(word_if.out_word_byte_cnt), 64'd4);
        idle(6);
        check("lastflush words", 64'(hs_cnt - hbase), 64'd1);
        check("lastflush pend", 64'(dut.r_flush_pend), 64'd0);

        // Reset mid-word drops partial bytes; next word is clean.
        push_bytes(2, 64'h0000E2E1);
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check("midrst cnt", 64'(word_if.out_word_byte_cnt), 64'd0);
        check("midrst data", 64'(word_if.out_word_data), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        push_bytes(4, 64'h58575655);
        wait_valid("midrst_next");
        check("midrst_next data", 64'(word_if.out_word_data), 64'h58575655);
        idle(3);

        check("no_read_while_empty", 64'(bad_rd), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
